ex_latch_ctl: RTL
=================

# ex_latch_ctl

Sequencing controller for the EX-stage pipeline latch (the 273-bit EX register with `stall`/`inv` controls). It decides, each cycle, whether the EX latch holds, loads a new op from RR, or loads a bubble. It also stretches spill ops to two MEM issue cycles and applies branch-mispredict flushes with a configurable wrong-path shadow. It exports stall/flush statistics and a MEM-hang watchdog.

## Interface
Parameters:
- `SHADOW`, default 1: cycles after a flush during which incoming RR ops are also squashed; range 0..7.
- `TIMEOUT`, default 255: consecutive `mem_busy` cycles, with a valid op held, that trip the watchdog; range 1..65535.

Ports:
- `clk` in 1: pipeline clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ex_v` in 1: EX latch `o_v`, the valid bit of the op currently in EX.
- `ex_spill` in 1: EX latch `o_spill`; the op needs two MEM issue cycles.
- `mem_busy` in 1: MEM cannot accept an issue this cycle.
- `flush` in 1: branch mispredict resolved downstream; kill EX and wrong-path ops.
- `ex_stall` out 1: drives EX latch `stall`; 1 = latch holds.
- `ex_inv` out 1: drives EX latch `inv`; forces a load even while stalled.
- `ex_vmask` out 1: ANDed into the latch input valid bit `in[0]`; 0 = load a bubble.
- `rr_stall` out 1: hold the RR stage (upstream of EX).
- `mem_issue` out 1: EX presents a valid issue to MEM this cycle.
- `spill_phase` out 1: 0 = first half of a spill, 1 = second half (also 0 for non-spill ops).
- `stall_cnt` out 16: saturating count of cycles with `ex_stall`=1 and `ex_inv`=0.
- `flush_cnt` out 8: saturating count of flush events.
- `wdog_err` out 1: sticky watchdog error.

## Operation
Registered state:
- `phase` (1 bit)
- `shadow_ctr` (3 bits)
- `busy_ctr` (16 bits)
- the two statistics counters
- `wdog_err`

Combinational terms:
- `need2 = ex_v & ex_spill & ~phase`
- `hold = ex_v & (mem_busy | need2)`

Output decode, in priority order:
1. **`flush`=1:**
   - `ex_inv`=1, `ex_vmask`=0, `ex_stall`=0, `rr_stall`=0, `mem_issue`=0.
   - Next cycle: `phase`←0, `shadow_ctr`←`SHADOW`, `busy_ctr`←0.
   - `flush` dominates `mem_busy` and spill sequencing.
2. **`shadow_ctr`≠0:**
   - `ex_vmask`=0; the latch loads a bubble whatever RR presents.
   - `ex_stall`=`hold` (always 0 in practice, since EX holds a bubble), `ex_inv`=0.
   - Next cycle: `shadow_ctr` decrements.
3. **Normal operation:**
   - `ex_stall`=`hold`, `rr_stall`=`hold`, `ex_vmask`=1, `ex_inv`=0.
   - `mem_issue` = `ex_v & ~mem_busy`.
   - `spill_phase` = `phase`.

Spill sequencing:
- If `need2` and `~mem_busy`, then `phase`←1. The latch holds, so the same op is presented again with `spill_phase`=1.
- If `phase`=1 and `~mem_busy`, then `phase`←0 and the latch loads normally.
- `mem_busy` during either phase freezes `phase`.

Watchdog:
- `busy_ctr` increments while `ex_v & mem_busy & ~flush`; it clears otherwise.
- When `busy_ctr` reaches `TIMEOUT`, `wdog_err`←1.
- `wdog_err` clears only on `rst`. It has no effect on pipeline control.

Counters:
- `stall_cnt` saturates at 16'hFFFF.
- `flush_cnt` saturates at 8'hFF.
- A flush that arrives while `shadow_ctr`≠0 restarts the shadow and counts as a new event.

## Timing
- Control outputs are combinational from state and inputs, with no added latency. The EX latch acts on them at the same clock edge.
- A non-spill op occupies EX for 1 cycle plus the number of `mem_busy` cycles. A spill op occupies EX for 2 cycles plus the number of `mem_busy` cycles.
- Flush → EX holds a bubble in the next cycle. RR output is squashed for `SHADOW` further cycles.
- Reset values:
  - Outputs with reset `ex_v`=0: `ex_stall`=0, `ex_inv`=0, `ex_vmask`=1, `rr_stall`=0, `mem_issue`=0, `spill_phase`=0.
  - Registers: `stall_cnt`=0, `flush_cnt`=0, `wdog_err`=0, `phase`=0, `shadow_ctr`=0, `busy_ctr`=0.
- Reset asserted mid-spill abandons the second phase; the first op after reset starts with `phase`=0.
- With `SHADOW`=0, flush squashes only the EX load in the flush cycle.

## Test plan
- **Back-to-back non-spill ops:** `ex_v`=1 each cycle, `mem_busy`=0 → `ex_stall`=0, `mem_issue`=1 every cycle, `stall_cnt` stays 0.
- **Spill op, MEM free:** `ex_v`=1, `ex_spill`=1, `mem_busy`=0.
  - Cycle 0: `spill_phase`=0, `ex_stall`=1, `rr_stall`=1, `mem_issue`=1.
  - Cycle 1: `spill_phase`=1, `ex_stall`=0.
  - Result: `stall_cnt`=1.
- **Spill op with MEM busy:** `mem_busy`=1 for 3 cycles in phase 1 → `phase` stays 1 and `ex_stall`=1 for those 3 cycles, then releases; `stall_cnt`=4.
- **Flush during spill phase 1 while `mem_busy`=1, `SHADOW`=2:**
  - Flush cycle: `ex_inv`=1, `ex_vmask`=0, `ex_stall`=0.
  - Next 2 cycles: `ex_vmask`=0.
  - Cycle 3: `ex_vmask`=1, `spill_phase`=0; `flush_cnt`=1.
- **Watchdog, `TIMEOUT`=4:** `ex_v`=1, `mem_busy`=1 held for 4 cycles → `wdog_err`=1 after the 4th edge and stays 1 after `mem_busy` drops. A following `rst` pulse clears it to 0.
- **Asynchronous reset:** `rst` asserted mid-spill, between clock edges → `phase`, counters and `wdog_err` go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_latch_ctl.sv
// EX-latch sequencer: hold/load/bubble control, two-cycle spill issue, flush shadow, stats, MEM watchdog.
// Latency: control outputs are combinational from state and inputs; state updates on the next rising edge.
// Backpressure: mem_busy or the first half of a spill holds EX and RR; flush overrides everything.
module ex_latch_ctl #(
  parameter int unsigned SHADOW  = 1,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_v,
  input  logic        ex_spill,
  input  logic        mem_busy,
  input  logic        flush,
  output logic        ex_stall,
  output logic        ex_inv,
  output logic        ex_vmask,
  output logic        rr_stall,
  output logic        mem_issue,
  output logic        spill_phase,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt,
  output logic        wdog_err
);

  logic        phase;
  logic [2:0]  shadow_ctr;
  logic [15:0] busy_ctr;
  logic        need2;
  logic        hold;
  logic        busy_inc;

  assign need2    = ex_v & ex_spill & ~phase;
  assign hold     = ex_v & (mem_busy | need2);
  assign busy_inc = ex_v & mem_busy & ~flush;

  // Decode latch controls: flush first, then wrong-path shadow, then normal hold/issue.
  always_comb begin
    ex_stall    = hold;
    ex_inv      = 1'b0;
    ex_vmask    = 1'b1;
    rr_stall    = hold;
    mem_issue   = ex_v & ~mem_busy;
    spill_phase = phase;
    if (flush) begin
      ex_inv      = 1'b1;
      ex_vmask    = 1'b0;
      ex_stall    = 1'b0;
      rr_stall    = 1'b0;
      mem_issue   = 1'b0;
      spill_phase = 1'b0;
    end else if (shadow_ctr != 3'd0) begin
      ex_vmask = 1'b0;
    end
  end

  // Spill phase and flush shadow sequencing; a flush restarts both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= 1'b0;
      shadow_ctr <= 3'd0;
    end else if (flush) begin
      phase      <= 1'b0;
      shadow_ctr <= 3'(SHADOW);
    end else begin
      if (!mem_busy) begin
        if (need2)
          phase <= 1'b1;
        else if (phase)
          phase <= 1'b0;
      end
      if (shadow_ctr != 3'd0)
        shadow_ctr <= shadow_ctr - 3'd1;
    end
  end

  // Watchdog: count consecutive busy cycles with a live op; trip sticky error at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_ctr <= 16'd0;
      wdog_err <= 1'b0;
    end else if (busy_inc) begin
      if (busy_ctr != 16'hFFFF)
        busy_ctr <= busy_ctr + 16'd1;
      if (busy_ctr >= 16'(TIMEOUT - 1))
        wdog_err <= 1'b1;
    end else begin
      busy_ctr <= 16'd0;
    end
  end

  // Saturating statistics: genuine stall cycles and flush events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 8'd0;
    end else begin
      if (ex_stall && !ex_inv && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (flush && flush_cnt != 8'hFF)
        flush_cnt <= flush_cnt + 8'd1;
    end
  end

endmodule
